// File: rtl/checksum_append.sv
// Streaming stage: forwards payload words unchanged, then appends one modular-sum
// checksum word (optionally negated) after the last word of every packet.
//
// state  | meaning
// PASS   | forwarding payload words, accumulating their sum
// APPEND | last word accepted; waiting to load the checksum beat
module checksum_append #(
  parameter int WIDTH     = 8,
  parameter int CSUM_MODE = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  typedef enum logic {ST_PASS, ST_APPEND} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             out_free;
  logic             s_accept;
  logic             load_csum;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] csum_hold;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] csum_nxt;

  assign out_free = !m_valid || m_ready;
  assign sum      = acc + s_data;
  assign csum_nxt = (CSUM_MODE == 1) ? (~sum + 1'b1) : sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_PASS;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PASS:   if (s_accept && s_last) state_nxt = ST_APPEND;
      ST_APPEND: if (out_free)           state_nxt = ST_PASS;
      default:                           state_nxt = ST_PASS;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    load_csum = 1'b0;
    case (state)
      ST_PASS:   s_ready   = rst_n && out_free;
      ST_APPEND: load_csum = out_free;
      default:   s_ready   = 1'b0;
    endcase
    s_accept = s_valid && s_ready;
  end

  // Single output stage; payload and checksum loads are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      acc       <= '0;
      csum_hold <= '0;
      pkt_count <= '0;
    end else begin
      if (s_accept) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_last  <= 1'b0;
        if (s_last) begin
          acc       <= '0;
          csum_hold <= csum_nxt;
        end else begin
          acc <= sum;
        end
      end else if (load_csum) begin
        m_valid <= 1'b1;
        m_data  <= csum_hold;
        m_last  <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (m_valid && m_ready && m_last) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_checksum_append.sv
// Scoreboard bench for checksum_append: three instances (8-bit sum, 16-bit sum,
// 8-bit negated sum) share clock and reset; a negedge monitor checks every output beat.
module tb_checksum_append;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid [3];
  logic [31:0] s_data  [3];
  logic        s_last  [3];
  logic        m_ready [3];
  logic        bp_en;

  logic        s_ready0, s_ready1, s_ready2;
  logic        m_valid0, m_valid1, m_valid2;
  logic        m_last0, m_last1, m_last2;
  logic [7:0]  m_data0;
  logic [15:0] m_data1;
  logic [7:0]  m_data2;
  logic [15:0] pkt_count0, pkt_count1, pkt_count2;

  logic        sr [3];
  logic        mv [3];
  logic        ml [3];
  logic [31:0] md [3];
  logic [15:0] pc [3];

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];
  logic [31:0] pkt[$];

  int vecs  = 0;
  int fails = 0;
  int stalls = 0;

  logic        prev_stall [3];
  logic [31:0] prev_data  [3];
  logic        prev_last  [3];
  logic [7:0]  run2;

  always #5 clk = ~clk;

  checksum_append #(.WIDTH(8), .CSUM_MODE(0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[0]), .s_ready(s_ready0),
    .s_data(s_data[0][7:0]), .s_last(s_last[0]), .m_valid(m_valid0),
    .m_ready(m_ready[0]), .m_data(m_data0), .m_last(m_last0), .pkt_count(pkt_count0));

  checksum_append #(.WIDTH(16), .CSUM_MODE(0), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[1]), .s_ready(s_ready1),
    .s_data(s_data[1][15:0]), .s_last(s_last[1]), .m_valid(m_valid1),
    .m_ready(m_ready[1]), .m_data(m_data1), .m_last(m_last1), .pkt_count(pkt_count1));

  checksum_append #(.WIDTH(8), .CSUM_MODE(1), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[2]), .s_ready(s_ready2),
    .s_data(s_data[2][7:0]), .s_last(s_last[2]), .m_valid(m_valid2),
    .m_ready(m_ready[2]), .m_data(m_data2), .m_last(m_last2), .pkt_count(pkt_count2));

  always_comb begin
    sr[0] = s_ready0;  sr[1] = s_ready1;  sr[2] = s_ready2;
    mv[0] = m_valid0;  mv[1] = m_valid1;  mv[2] = m_valid2;
    ml[0] = m_last0;   ml[1] = m_last1;   ml[2] = m_last2;
    md[0] = {24'h0, m_data0};
    md[1] = {16'h0, m_data1};
    md[2] = {24'h0, m_data2};
    pc[0] = pkt_count0; pc[1] = pkt_count1; pc[2] = pkt_count2;
  end

  initial begin
    for (int d = 0; d < 3; d++) m_ready[d] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) m_ready[d] = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push(input int d, input logic [32:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] exp;
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) prev_stall[d] = 1'b0;
      run2 = 8'h0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (prev_stall[d]) begin
          vecs++;
          if (!(mv[d] && md[d] == prev_data[d] && ml[d] == prev_last[d])) begin
            fails++;
            $display("FAIL stable dut%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                     d, mv[d], md[d], ml[d], prev_data[d], prev_last[d]);
          end
        end
        if (mv[d] && m_ready[d]) begin
          vecs++;
          if (qsize(d) == 0) begin
            fails++;
            $display("FAIL extra_beat dut%0d: got d=%h l=%b, expected no beat", d, md[d], ml[d]);
          end else begin
            case (d)
              0:       exp = q0.pop_front();
              1:       exp = q1.pop_front();
              default: exp = q2.pop_front();
            endcase
            if ({ml[d], md[d]} !== exp) begin
              fails++;
              $display("FAIL beat dut%0d: got l=%b d=%h, expected l=%b d=%h",
                       d, ml[d], md[d], exp[32], exp[31:0]);
            end
            if (d == 2) begin
              run2 = run2 + md[2][7:0];
              if (ml[2]) begin
                vecs++;
                if (run2 !== 8'h00) begin
                  fails++;
                  $display("FAIL zero_sum dut2: got %h, expected 00", run2);
                end
                run2 = 8'h0;
              end
            end
          end
        end
        prev_stall[d] = mv[d] && !m_ready[d];
        prev_data[d]  = md[d];
        prev_last[d]  = ml[d];
      end
    end
  end

  task automatic send_beat(input int d, input logic [31:0] data, input logic last);
    int  budget;
    bit  done;
    budget = 0;
    done   = 1'b0;
    s_valid[d] = 1'b1;
    s_data[d]  = data;
    s_last[d]  = last;
    while (!done) begin
      @(negedge clk);
      if (sr[d]) done = 1'b1;
      else if (d == 0) stalls++;
      @(posedge clk);
      #2;
      budget++;
      if (!done && budget > 500) begin
        vecs++;
        fails++;
        $display("FAIL accept_timeout dut%0d: got no s_ready, expected accept of %h", d, data);
        done = 1'b1;
      end
    end
  endtask

  // Sends the words in pkt; csum is the hand-computed (or reference) checksum word.
  task automatic send_pkt(input int d, input logic [31:0] csum);
    for (int i = 0; i < pkt.size(); i++) begin
      push(d, {1'b0, pkt[i]});
      if (i == pkt.size() - 1) push(d, {1'b1, csum});
      send_beat(d, pkt[i], i == pkt.size() - 1);
    end
  endtask

  task automatic idle(input int d);
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
  endtask

  task automatic drain(input int d);
    int budget;
    budget = 0;
    while (qsize(d) != 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (qsize(d) != 0) begin
      vecs++;
      fails++;
      $display("FAIL drain_timeout dut%0d: got %0d beats pending, expected 0", d, qsize(d));
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] ref_sum;
    int         n;
    bp_en = 1'b0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      s_valid[d] = 1'b0;
      s_data[d]  = 32'h0;
      s_last[d]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", {31'h0, m_valid0}, 32'h0);
    check("rst_m_data", md[0], 32'h0);
    check("rst_m_last", {31'h0, m_last0}, 32'h0);
    check("rst_pkt_count", {16'h0, pkt_count0}, 32'h0);
    check("rst_s_ready", {31'h0, s_ready0}, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic packet followed by back-to-back packets with s_valid held high.
    stalls = 0;
    pkt = '{32'h01, 32'h02, 32'h03};
    send_pkt(0, 32'h06);
    pkt = '{32'hAA};
    send_pkt(0, 32'hAA);
    pkt = '{32'h01, 32'h01};
    send_pkt(0, 32'h02);
    idle(0);
    check("stall_cycles", stalls, 32'd2);
    drain(0);
    check("pkt_count_b2b", {16'h0, pkt_count0}, 32'd3);

    pkt = '{32'hFF, 32'h02};
    send_pkt(0, 32'h01);
    idle(0);
    drain(0);
    check("pkt_count_wrap8", {16'h0, pkt_count0}, 32'd4);

    pkt = '{32'hFFFF, 32'hFFFF, 32'h0003};
    send_pkt(1, 32'h0001);
    idle(1);
    drain(1);
    check("pkt_count_w16", {16'h0, pkt_count1}, 32'd1);

    pkt = '{32'h10, 32'h20};
    send_pkt(2, 32'hD0);
    idle(2);
    pkt = '{32'h05};
    send_pkt(2, 32'hFB);
    idle(2);
    drain(2);
    check("pkt_count_neg", {16'h0, pkt_count2}, 32'd2);

    // Reset mid-packet: 07,08 are forwarded, their partial sum must be discarded.
    push(0, {1'b0, 32'h07});
    send_beat(0, 32'h07, 1'b0);
    push(0, {1'b0, 32'h08});
    send_beat(0, 32'h08, 1'b0);
    idle(0);
    drain(0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_m_valid", {31'h0, m_valid0}, 32'h0);
    check("midrst_pkt_count", {16'h0, pkt_count0}, 32'h0);
    check("midrst_s_ready", {31'h0, s_ready0}, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    pkt = '{32'h03};
    send_pkt(0, 32'h03);
    idle(0);
    drain(0);
    check("pkt_count_after_rst", {16'h0, pkt_count0}, 32'd1);

    // Random backpressure over 20 packets of 1..16 words.
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bp_en = 1'b1;
    for (int p = 0; p < 20; p++) begin
      n = (p * 7) % 16 + 1;
      ref_sum = 8'h0;
      pkt = {};
      for (int i = 0; i < n; i++) begin
        pkt.push_back({24'h0, 8'($urandom_range(0, 255))});
        ref_sum = ref_sum + pkt[i][7:0];
      end
      send_pkt(0, {24'h0, ref_sum});
      if (p % 3 == 0) begin
        idle(0);
        @(posedge clk);
        #2;
      end
    end
    idle(0);
    drain(0);
    bp_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pkt_count_bp", {16'h0, pkt_count0}, 32'd20);
    check("queue_empty", qsize(0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/checksum_append.md
Name: checksum_append

Overview:
- Streaming RTL stage that forwards packet words unchanged, then appends one checksum word at the end of each packet.
- Sits directly upstream of the scoreboard's checksum model. The appended word must equal that model's modular sum (checksum8/16/32) of the packet payload words.
- Valid/ready handshake on both sides; packets are delimited by a last flag.

Parameters:
- WIDTH, 8, data and checksum width in bits; legal values 8, 16, 32.
- CSUM_MODE, 0, 0 = plain modular sum; 1 = two's-complement of the sum, so payload plus checksum sums to 0.
- CNT_WIDTH, 16, width of the packet counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  WIDTH  payload word
- s_last  in  1  final payload word of packet
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  WIDTH  payload word or checksum word
- m_last  out  1  high only on the checksum beat
- pkt_count  out  CNT_WIDTH  number of checksum beats handshaken on the output

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n low at a clk edge):
  - m_valid=0, m_data=0, m_last=0, pkt_count=0.
  - Accumulator=0, checksum holding register=0, state=PASS.
  - s_ready is low while rst_n is low.
- Reset mid-packet: the partial packet is discarded, no checksum beat is emitted, and the accumulator is cleared.
- Output register: a single stage holding m_valid/m_data/m_last.
  - Free = !m_valid || m_ready.
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - m_valid never drops without a handshake.
- State PASS:
  - s_ready = free.
  - On input accept: the output register loads s_data with m_last=0 and m_valid=1, so latency is 1 cycle.
  - Accumulator update: acc <= acc + s_data, mod 2^WIDTH, carries discarded.
  - If s_last is set on the accepted beat:
    - sum = acc + s_data.
    - Checksum holding register <= sum when CSUM_MODE=0, or (~sum + 1) mod 2^WIDTH when CSUM_MODE=1.
    - acc <= 0; state <= APPEND.
- State APPEND:
  - s_ready = 0.
  - When the output register is free: load the checksum holding register with m_last=1 and m_valid=1; state <= PASS.
  - The checksum beat therefore appears the cycle after the last payload beat leaves the output register. If m_ready was high, the two beats are back-to-back.
- Throughput: an N-word packet produces N+1 output beats. Input is stalled exactly one cycle per packet when the output is unstalled.
- Back-to-back packets: the first word of the next packet may be accepted in the cycle after the checksum beat is loaded. The accumulator is already 0, so there is no carry-over between packets.
- Single-word packet: checksum = that word (CSUM_MODE=0) or its negation (CSUM_MODE=1).
- pkt_count increments on the m_valid && m_ready && m_last handshake and wraps at 2^CNT_WIDTH.
- s_data and s_last are ignored when s_valid=0. No empty packets: every packet carries at least one payload word.

Test Plan:
- WIDTH=8, CSUM_MODE=0, m_ready=1, packet {01,02,03} -> output 01,02,03,06; m_last only on 06; pkt_count=1; exactly one stall cycle on s_ready.
- Wrap-around: packet {FF,02} -> checksum 01. WIDTH=16 packet {FFFF,FFFF,0003} -> checksum 0001.
- CSUM_MODE=1, WIDTH=8, packet {10,20} -> checksum D0. Bench check: sum of all 3 output words mod 256 = 0. Single-word {05} -> FB.
- Backpressure: random m_ready (~50%) over 20 packets of 1-16 words. Required: m_data/m_last stable while stalled, no lost or duplicated beats, and every checksum equals the checksum8 reference. pkt_count=20.
- Back-to-back: packets {AA} then {01,01} with s_valid held high -> output AA,AA,01,01,02. The second checksum is unaffected by the first packet.
- Reset mid-packet: accept {07,08} (no last), assert rst_n low for 1 cycle, then send {03,last} -> output 03,03 only; m_valid=0 and pkt_count=0 during reset; afterwards pkt_count=1.
